count_pattern_detector: RTL and testbench
=========================================

COUNT_PATTERN_DETECTOR -- requirements
Module: count_pattern_detector

Interface
REQ-001 Parameter PAT0, default 3'd3, meaning first value of the detected sequence.
REQ-002 Parameter PAT1, default 3'd5, meaning second value of the detected sequence.
REQ-003 Parameter PAT2, default 3'd6, meaning third value of the detected sequence.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 valid  input  1  count_in is sampled only when high; driven from the upstream counter's enable.
REQ-007 count_in  input  3  value from the upstream 3-bit counter's count output.
REQ-008 clear  input  1  synchronous clear of hit_count only.
REQ-009 hit  output  1  one-cycle registered pulse on sequence completion.
REQ-010 hit_count  output  8  number of detections, saturating.
REQ-011 state_out  output  2  current FSM state, for bench probing.

Function
REQ-012 The FSM SHALL have three states: IDLE=2'd0, GOT0=2'd1, GOT1=2'd2; the code 2'd3 is illegal.
REQ-013 When valid is low, the state SHALL hold, the input SHALL be ignored, and hit SHALL be 0 on the next cycle.
REQ-014 From IDLE, on a valid sample: count_in==PAT0 -> GOT0; otherwise -> IDLE.
REQ-015 From GOT0, on a valid sample: PAT1 -> GOT1; PAT0 -> GOT0; otherwise -> IDLE.
REQ-016 From GOT1, on a valid sample: PAT2 -> IDLE with a detection; PAT0 -> GOT0; otherwise -> IDLE.
REQ-017 The illegal state SHALL transition to IDLE on the next clock, regardless of valid, with no detection.
REQ-018 hit SHALL be high for exactly the one cycle after the edge that samples the completing PAT2; latency is 1 clock.
REQ-019 hit_count SHALL increment on the same edge that sets hit, saturate at 8'd255, and never wrap.
REQ-020 When clear and a detection occur on the same edge, clear SHALL win: hit_count=0 and hit=1.
REQ-021 clear SHALL NOT affect the FSM state or hit.
REQ-022 Sequences SHALL be matched only across consecutive valid samples; any number of intervening valid-low cycles is transparent.
REQ-023 Detections SHALL NOT overlap: after a detection, matching restarts from IDLE.

Reset
REQ-024 While reset==0 at a rising edge: state=IDLE, hit=0, hit_count=0, and all other inputs are ignored.
REQ-025 A reset asserted mid-sequence (GOT0 or GOT1) SHALL discard partial progress; no hit SHALL follow.
REQ-026 state_out SHALL reflect IDLE (2'd0) in the cycle after reset.

Structure
REQ-027 Shared package count_pkg SHALL hold the state encodings (IDLE, GOT0, GOT1) and the default PAT0..PAT2 constants, for reuse with the upstream counter's bench.
REQ-028 Saturating counting SHALL be in a sub-module sat_counter: 8-bit, with inc, clr (priority), synchronous active-low reset, and saturation at max.
REQ-029 PAT0, PAT1 and PAT2 SHALL be pairwise distinct; an elaboration-time check SHALL flag a violation.

Verification
REQ-030 Reset released, valid=1, count_in 3,5,6 on consecutive cycles -> hit=1 one cycle after the 6 is sampled, hit_count=1, state_out back to 0.
REQ-031 count_in 3, valid=0 for 4 cycles, then 5,6 with valid=1 -> exactly one hit, hit_count=1.
REQ-032 count_in 3,3,5,6 -> one hit; count_in 3,5,3,5,6 -> one hit; count_in 3,5,7,6 -> no hit.
REQ-033 300 back-to-back 3,5,6 triplets -> hit_count stops at 255; the next detection still pulses hit and hit_count stays 255.
REQ-034 clear=1 on the edge of a detection -> hit=1, hit_count=0; clear alone -> state_out unchanged.
REQ-035 reset=0 while in GOT1, then release and drive 6 -> no hit; state_out=0, hit_count=0.

Source files
------------

// File: rtl/count_pkg.sv
// Shared encodings and default sequence for the count pattern detector.
// Reused by the upstream counter's bench.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT0 = 2'd1,
        GOT1 = 2'd2
    } state_t;

    localparam logic [2:0] DEF_PAT0 = 3'd3;
    localparam logic [2:0] DEF_PAT1 = 3'd5;
    localparam logic [2:0] DEF_PAT2 = 3'd6;

    localparam int HIT_W = 8;

    function automatic logic pats_distinct(
        input logic [2:0] a,
        input logic [2:0] b,
        input logic [2:0] c
    );
        return (a != b) && (a != c) && (b != c);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with priority clear.
// Synchronous active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_pattern_detector.sv
// Detects PAT0,PAT1,PAT2 across consecutive valid samples
// and counts non-overlapping detections.
module count_pattern_detector
    import count_pkg::*;
#(
    parameter logic [2:0] PAT0 = DEF_PAT0,
    parameter logic [2:0] PAT1 = DEF_PAT1,
    parameter logic [2:0] PAT2 = DEF_PAT2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       count_in,
    input  logic             clear,
    output logic             hit,
    output logic [HIT_W-1:0] hit_count,
    output logic [1:0]       state_out
);

    generate
        if (!pats_distinct(PAT0, PAT1, PAT2)) begin : g_pat_check
            $error("PAT0, PAT1 and PAT2 must be pairwise distinct");
        end
    endgenerate

    state_t state;
    state_t state_nx;
    logic   detect;

    always_comb begin
        state_nx = state;
        detect   = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nx = (count_in == PAT0) ? GOT0 : IDLE;
                end
            end
            GOT0: begin
                if (valid) begin
                    if (count_in == PAT1)
                        state_nx = GOT1;
                    else if (count_in == PAT0)
                        state_nx = GOT0;
                    else
                        state_nx = IDLE;
                end
            end
            GOT1: begin
                if (valid) begin
                    if (count_in == PAT2) begin
                        state_nx = IDLE;
                        detect   = 1'b1;
                    end else if (count_in == PAT0) begin
                        state_nx = GOT0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            // Unreachable code 2'd3 recovers unconditionally.
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            hit   <= 1'b0;
        end else begin
            state <= state_nx;
            hit   <= detect;
        end
    end

    sat_counter #(
        .W(HIT_W)
    ) u_hits (
        .clk  (clk),
        .rst_n(reset),
        .inc  (detect),
        .clr  (clear),
        .count(hit_count)
    );

    assign state_out = state;

endmodule

// File: tb/tb_count_pattern_detector.sv
// Self-checking bench for count_pattern_detector.
// Sequence-level model plus directed literal expectations.
module tb_count_pattern_detector;

    localparam int P0 = 3;
    localparam int P1 = 5;
    localparam int P2 = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] count_in = 3'd0;
    logic       clear = 1'b0;
    logic       hit;
    logic [7:0] hit_count;
    logic [1:0] state_out;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    int hist[$];
    int m_hit = 0;
    int m_cnt = 0;
    int m_state = 0;

    count_pattern_detector dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .count_in (count_in),
        .clear    (clear),
        .hit      (hit),
        .hit_count(hit_count),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    // Model: keep recent valid samples since the last restart;
    // a detection is the tail equal to P0,P1,P2.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                hist.delete();
                m_hit = 0;
                m_cnt = 0;
            end else begin
                m_hit = 0;
                if (valid) begin
                    int n;
                    hist.push_back(int'(count_in));
                    n = hist.size();
                    if (n >= 3 && hist[n-3] == P0 && hist[n-2] == P1
                        && hist[n-1] == P2) begin
                        m_hit = 1;
                        hist.delete();
                        if (m_cnt < 255) m_cnt++;
                    end
                    while (hist.size() > 3) void'(hist.pop_front());
                end
                if (clear) m_cnt = 0;
            end
            begin
                int n;
                n = hist.size();
                if (n >= 2 && hist[n-2] == P0 && hist[n-1] == P1)
                    m_state = 2;
                else if (n >= 1 && hist[n-1] == P0)
                    m_state = 1;
                else
                    m_state = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_hit", int'(hit), m_hit);
                check("model_hit_count", int'(hit_count), m_cnt);
                check("model_state", int'(state_out), m_state);
            end
        end
    end

    task automatic step(input bit v, input int c, input bit cl = 1'b0);
        valid    = v;
        count_in = 3'(c);
        clear    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic seq3;
        step(1, P0);
        step(1, P1);
        step(1, P2);
    endtask

    initial begin
        reset = 1'b0;
        step(1, P0, 1'b1);
        step(1, P1);
        chk_en = 1'b1;
        check("reset_state", int'(state_out), 0);
        check("reset_hit", int'(hit), 0);
        check("reset_count", int'(hit_count), 0);
        reset = 1'b1;

        // Basic detection, 1-clock latency
        step(1, 3);
        check("got0", int'(state_out), 1);
        step(1, 5);
        check("got1", int'(state_out), 2);
        step(1, 6);
        check("basic_hit", int'(hit), 1);
        check("basic_count", int'(hit_count), 1);
        check("basic_state", int'(state_out), 0);
        step(0, 3);
        check("hit_one_cycle", int'(hit), 0);

        // Valid-low gaps are transparent
        step(1, 3);
        repeat (4) step(0, 7);
        check("gap_hold", int'(state_out), 1);
        step(1, 5);
        step(1, 6);
        check("gap_hit", int'(hit), 1);
        check("gap_count", int'(hit_count), 2);

        step(1, 3); step(1, 3); step(1, 5); step(1, 6);
        check("335_6_hit", int'(hit), 1);
        step(1, 3); step(1, 5); step(1, 3); step(1, 5); step(1, 6);
        check("35356_hit", int'(hit), 1);
        check("35356_count", int'(hit_count), 4);
        step(1, 3); step(1, 5); step(1, 7); step(1, 6);
        check("3576_nohit", int'(hit), 0);
        check("3576_count", int'(hit_count), 4);

        // Clear alone leaves the FSM alone; clear beats a detection
        step(1, 3);
        step(0, 0, 1'b1);
        check("clr_state", int'(state_out), 1);
        check("clr_count", int'(hit_count), 0);
        step(1, 5);
        step(1, 6, 1'b1);
        check("clr_win_hit", int'(hit), 1);
        check("clr_win_count", int'(hit_count), 0);

        // Saturation
        repeat (300) seq3();
        check("sat_count", int'(hit_count), 255);
        seq3();
        check("sat_hit", int'(hit), 1);
        check("sat_hold", int'(hit_count), 255);

        // Reset mid-sequence discards progress
        step(1, 3);
        step(1, 5);
        check("pre_rst_state", int'(state_out), 2);
        reset = 1'b0;
        step(1, 6);
        check("rst_state", int'(state_out), 0);
        check("rst_count", int'(hit_count), 0);
        reset = 1'b1;
        step(1, 6);
        check("post_rst_hit", int'(hit), 0);
        check("post_rst_state", int'(state_out), 0);
        check("post_rst_count", int'(hit_count), 0);
        step(0, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
